// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three buses around the data-memory arbiter:
//   CPU MEM-stage port : cpu_req/cpu_we/cpu_addr/cpu_wdata in,
//                        cpu_gnt/cpu_rvalid/cpu_rdata out
//   Debug/loader port  : dbg_req/dbg_we/dbg_addr/dbg_len/dbg_wdata in,
//                        dbg_gnt/dbg_rvalid/dbg_rdata/dbg_busy out
//   Memory port        : mem_wr_en/mem_addr/mem_din out, mem_dout in
//   Status             : access_err out
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding logic (requesters plus memory).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 8
);
  logic            cpu_req;
  logic            cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic            cpu_gnt;
  logic            cpu_rvalid;
  logic [DW-1:0]   cpu_rdata;

  logic            dbg_req;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [LENW-1:0] dbg_len;
  logic [DW-1:0]   dbg_wdata;
  logic            dbg_gnt;
  logic            dbg_rvalid;
  logic [DW-1:0]   dbg_rdata;
  logic            dbg_busy;

  logic            access_err;

  logic            mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_busy,
    output access_err,
    output mem_wr_en, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_busy,
    input  access_err,
    input  mem_wr_en, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port, word-organised, byte-addressed data memory between
// the CPU MEM stage (single-word accesses) and a debug/loader port (bursts of
// dbg_len+1 words). Memory reads are synchronous: data is valid on mem_dout
// the cycle after the address, and is routed back to whichever side issued
// the read.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    dmem_arbiter_if.slave (CPU port, debug port, memory port,
//          access_err)
//
// Optional feature, enabled by defining DMEM_ALIGN_CHECK_EN:
//   accesses with addr[1:0] != 0 still take their grant, but writes are
//   suppressed, reads return zero data, and access_err pulses in the grant
//   cycle. Without the macro access_err is tied 0 and addresses pass through.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 8
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CPU  = 2'd1;
  localparam logic [1:0] DBG  = 2'd2;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  logic [1:0]      state;
  logic            lastOwner;
  logic [AW-1:0]   addrReg;     // next burst beat address
  logic [LENW-1:0] remaining;   // burst beats still to issue after this one
  logic            weReg;       // burst direction latched at start
  logic [AW-1:0]   memAddrQ;    // last issued address, held when idle
  logic [DW-1:0]   memDinQ;     // last issued write data, held when idle
  logic            cpuRdPend;   // read return tags, one cycle after grant
  logic            dbgRdPend;
  logic            rdErrQ;      // returning read was misaligned
  logic [DW-1:0]   cpuRdataQ;   // held read data per requester
  logic [DW-1:0]   dbgRdataQ;

  logic            arbitrating;
  logic            cpuWin;
  logic            cpuGnt;
  logic            dbgGnt;
  logic            anyGnt;
  logic            anyGntOut;
  logic [AW-1:0]   gntAddr;
  logic [DW-1:0]   gntData;
  logic            gntWe;
  logic            misaligned;
  logic [DW-1:0]   rdData;

  // ---------------------------------------------------------------------------
  // Arbitration and access selection
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    arbitrating = (state != DBG);
    // Round-robin on contention: whoever did not go last wins. This also
    // gives the CPU the cycle after a burst, since a burst leaves
    // lastOwner = DBG.
    cpuWin      = bus.cpu_req && (!bus.dbg_req || lastOwner == OWNER_DBG);
    cpuGnt      = arbitrating && cpuWin;
    dbgGnt      = arbitrating ? (bus.dbg_req && !cpuWin) : 1'b1;
    anyGnt      = cpuGnt || dbgGnt;

    gntAddr     = bus.dbg_addr;
    gntData     = bus.dbg_wdata;
    gntWe       = bus.dbg_we;
    if (!arbitrating) begin
      gntAddr = addrReg;
      gntWe   = weReg;
    end else if (cpuWin) begin
      gntAddr = bus.cpu_addr;
      gntData = bus.cpu_wdata;
      gntWe   = bus.cpu_we;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // A misaligned burst start stays misaligned on every +4 beat, so checking
  // the issued address flags each beat of such a burst.
  assign misaligned = (gntAddr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The flops are held in reset anyway, so only the outputs need masking to
  // read as zero while reset is asserted.
  assign anyGntOut      = anyGnt && reset;

  assign bus.cpu_gnt    = cpuGnt && reset;
  assign bus.dbg_gnt    = dbgGnt && reset;
  assign bus.dbg_busy   = dbgGnt && reset;
  assign bus.access_err = anyGntOut && misaligned;
  assign bus.mem_wr_en  = anyGntOut && gntWe && !misaligned;
  assign bus.mem_addr   = anyGntOut ? gntAddr : memAddrQ;
  assign bus.mem_din    = anyGntOut ? gntData : memDinQ;

  // Read return: the live memory output goes to the tagged owner, the other
  // side keeps showing its last returned word.
  assign rdData         = rdErrQ ? '0 : bus.mem_dout;
  assign bus.cpu_rvalid = cpuRdPend;
  assign bus.dbg_rvalid = dbgRdPend;
  assign bus.cpu_rdata  = cpuRdPend ? rdData : cpuRdataQ;
  assign bus.dbg_rdata  = dbgRdPend ? rdData : dbgRdataQ;

  // ---------------------------------------------------------------------------
  // State, burst tracking and read tags
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register here, including the data holders, is reset so the
    // memory-side outputs come up as defined zeros rather than X.
    if (!reset) begin
      state     <= IDLE;
      lastOwner <= OWNER_DBG;
      addrReg   <= '0;
      remaining <= '0;
      weReg     <= 1'b0;
      memAddrQ  <= '0;
      memDinQ   <= '0;
      cpuRdPend <= 1'b0;
      dbgRdPend <= 1'b0;
      rdErrQ    <= 1'b0;
      cpuRdataQ <= '0;
      dbgRdataQ <= '0;
    end else begin
      cpuRdPend <= cpuGnt && !gntWe;
      dbgRdPend <= dbgGnt && !gntWe;
      rdErrQ    <= anyGnt && !gntWe && misaligned;

      if (cpuRdPend) cpuRdataQ <= rdData;
      if (dbgRdPend) dbgRdataQ <= rdData;

      if (anyGnt) begin
        memAddrQ <= gntAddr;
        memDinQ  <= gntData;
      end

      if (!arbitrating) begin
        // Burst beat: address wraps naturally modulo 2^AW.
        addrReg   <= addrReg + AW'(4);
        remaining <= remaining - LENW'(1);
        if (remaining == LENW'(1)) state <= IDLE;
      end else if (cpuGnt) begin
        state     <= CPU;
        lastOwner <= OWNER_CPU;
      end else if (dbgGnt) begin
        // Burst start beat; dbg_len beats follow in the DBG state.
        addrReg   <= bus.dbg_addr + AW'(4);
        weReg     <= bus.dbg_we;
        remaining <= bus.dbg_len;
        lastOwner <= OWNER_DBG;
        state     <= (bus.dbg_len != '0) ? DBG : IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A behavioural synchronous memory sits
// on the memory port; expected read data is queued when a read is granted and
// compared when the matching rvalid appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk;
  logic reset;

  dmem_arbiter_if #(.AW(32), .DW(32), .LENW(8)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .LENW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] cpuExp[$];
  logic [31:0] dbgExp[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory model: address/controls sampled mid-cycle, applied at the edge,
  // read data valid the cycle after the address.
  // ---------------------------------------------------------------------------
  logic [31:0] memArr [logic [29:0]];
  logic [31:0] sAddr = '0;
  logic [31:0] sDin  = '0;
  logic        sWe   = 1'b0;

  always @(negedge clk) begin
    sAddr = bus.mem_addr;
    sDin  = bus.mem_din;
    sWe   = bus.mem_wr_en;
  end

  always @(posedge clk) begin
    logic [31:0] rd;
    rd = memArr.exists(sAddr[31:2]) ? memArr[sAddr[31:2]] : 32'h0;
    if (sWe) memArr[sAddr[31:2]] = sDin;
    bus.mem_dout <= rd;
  end

  // ---------------------------------------------------------------------------
  // Read-return scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (bus.cpu_rvalid === 1'b1) begin
      if (cpuExp.size() == 0) check("cpu_rvalid_spurious", 1, 0);
      else                    check("cpu_rdata", bus.cpu_rdata, cpuExp.pop_front());
    end
    if (bus.dbg_rvalid === 1'b1) begin
      if (dbgExp.size() == 0) check("dbg_rvalid_spurious", 1, 0);
      else                    check("dbg_rdata", bus.dbg_rdata, dbgExp.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks (called at posedge+1, return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpuOp(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic expErr, input string tag, output int waited);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = we ? data : 32'h0;
    waited = 0;
    @(negedge clk);
    while (bus.cpu_gnt !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check({tag, "_gnt"},      bus.cpu_gnt, 1);
    check({tag, "_dbg_gnt"},  bus.dbg_gnt, 0);
    check({tag, "_addr"},     bus.mem_addr, addr);
    check({tag, "_wr_en"},    bus.mem_wr_en, we && !expErr);
    check({tag, "_err"},      bus.access_err, expErr);
    if (we) check({tag, "_din"}, bus.mem_din, data);
    else    cpuExp.push_back(data);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic dbgBurst(input logic we, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input string tag, output int waited);
    logic [31:0] ea;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_len   = len;
    bus.dbg_wdata = base;
    waited = 0;
    @(negedge clk);
    while (bus.dbg_gnt !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0) @(negedge clk);
      ea = addr + 32'(i * 4);
      check({tag, "_gnt"},     bus.dbg_gnt, 1);
      check({tag, "_busy"},    bus.dbg_busy, 1);
      check({tag, "_cpu_gnt"}, bus.cpu_gnt, 0);
      check({tag, "_addr"},    bus.mem_addr, ea);
      check({tag, "_wr_en"},   bus.mem_wr_en, we);
      if (we) check({tag, "_din"}, bus.mem_din, base + 32'(i));
      else begin
        dbgExp.push_back(base + 32'(i));
        if (i > 0) check({tag, "_rvalid_stream"}, bus.dbg_rvalid, 1);
      end
      @(posedge clk);
      #1;
      bus.dbg_req   = 1'b0;
      bus.dbg_wdata = base + 32'(i + 1);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_cpu_gnt"},    bus.cpu_gnt, 0);
    check({tag, "_dbg_gnt"},    bus.dbg_gnt, 0);
    check({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
    check({tag, "_dbg_rvalid"}, bus.dbg_rvalid, 0);
    check({tag, "_busy"},       bus.dbg_busy, 0);
    check({tag, "_wr_en"},      bus.mem_wr_en, 0);
    check({tag, "_err"},        bus.access_err, 0);
    check({tag, "_addr"},       bus.mem_addr, 0);
    check({tag, "_din"},        bus.mem_din, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int wc, wc2, wd, wd2;
    clk           = 1'b0;
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_len   = '0;
    bus.dbg_wdata = '0;

    #12;
    checkAllZero("reset");
    reset = 1'b1;
    idle(1);

    // CPU writes on consecutive cycles, then reads back.
    for (int i = 1; i <= 4; i++) begin
      cpuOp(1'b1, 32'(i * 4), 32'(i), 1'b0, "cpu_wr", wc);
      check("cpu_wr_wait", wc, 0);
    end
    @(negedge clk);
    check("hold_wr_en", bus.mem_wr_en, 0);
    check("hold_addr",  bus.mem_addr, 32'h10);
    check("hold_din",   bus.mem_din, 32'h4);
    idle(1);
    for (int i = 1; i <= 4; i++) begin
      cpuOp(1'b0, 32'(i * 4), 32'(i), 1'b0, "cpu_rd", wc);
      check("cpu_rd_wait", wc, 0);
    end
    idle(2);

`ifdef DMEM_ALIGN_CHECK_EN
    cpuOp(1'b1, 32'h06, 32'hDEAD, 1'b1, "misalign_wr", wc);
    cpuOp(1'b0, 32'h04, 32'h1, 1'b0, "after_misalign_rd", wc);
`else
    cpuOp(1'b0, 32'h06, 32'h1, 1'b0, "unaligned_rd", wc);
`endif
    idle(2);

    // Debug write burst with a held CPU read that stalls behind it.
    fork
      dbgBurst(1'b1, 32'h20, 8'd3, 32'hA, "burst_wr", wd);
      cpuOp(1'b0, 32'h24, 32'hB, 1'b0, "stalled_rd", wc);
    join
    check("burst_wr_wait", wd, 0);
    check("stalled_rd_wait", wc, 4);
    idle(3);

    // Round-robin after a fresh reset (last owner = DBG).
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    fork
      begin
        cpuOp(1'b0, 32'h04, 32'h1, 1'b0, "rr_cpu_a", wc);
        cpuOp(1'b0, 32'h08, 32'h2, 1'b0, "rr_cpu_b", wc2);
      end
      begin
        dbgBurst(1'b0, 32'h20, 8'd1, 32'hA, "rr_burst1", wd);
        dbgBurst(1'b0, 32'h24, 8'd0, 32'hB, "rr_burst2", wd2);
      end
    join
    check("rr_cpu_a_wait", wc, 0);
    check("rr_burst1_wait", wd, 1);
    check("rr_cpu_b_wait", wc2, 2);
    check("rr_burst2_wait", wd2, 1);
    idle(3);

    // Address wrap at the top of the address space.
    dbgBurst(1'b1, 32'hFFFF_FFF8, 8'd2, 32'h11, "wrap_wr", wd);
    dbgBurst(1'b0, 32'hFFFF_FFF8, 8'd2, 32'h11, "wrap_rd", wd);
    check("wrap_rd_wait", wd, 0);
    idle(3);

    // Reset in the third beat of an 8-beat burst.
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 32'h40;
    bus.dbg_len   = 8'd7;
    bus.dbg_wdata = 32'h50;
    @(negedge clk);
    check("abort_beat0_gnt", bus.dbg_gnt, 1);
    @(posedge clk);
    #1;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    check("abort_beat1_addr", bus.mem_addr, 32'h44);
    @(negedge clk);
    check("abort_beat2_addr", bus.mem_addr, 32'h48);
    check("abort_beat2_busy", bus.dbg_busy, 1);
    #1;
    reset = 1'b0;
    #1;
    checkAllZero("abort");
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check("no_resume_dbg_gnt", bus.dbg_gnt, 0);
    check("no_resume_busy",    bus.dbg_busy, 0);
    idle(1);
    cpuOp(1'b0, 32'h0C, 32'h3, 1'b0, "post_abort_rd", wc);
    check("post_abort_rd_wait", wc, 0);
    idle(3);

    check("cpu_queue_drained", cpuExp.size(), 0);
    check("dbg_queue_drained", dbgExp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data-memory stage between two requesters: the CPU MEM stage (single-word accesses) and a debug/loader port (word bursts).
- Drives the memory's write-enable, byte address and write data, and routes the read data back to the requester that issued the read.
- Sits between the pipeline MEM stage/debug interface and the data-memory stage.
- Memory is word-organised and byte-addressed: word = addr>>2, addresses step by 4, synchronous read with data valid the cycle after the address.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- LENW, 8, burst-length field width; a burst is dbg_len+1 words, maximum 2^LENW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  DW  write data.
- cpu_gnt  out  1  access accepted this cycle; pipeline stalls while cpu_req=1 and cpu_gnt=0.
- cpu_rvalid  out  1  read data valid (1 cycle after the granted read).
- cpu_rdata  out  DW  read data.
- dbg_req  in  1  burst request, held until the first beat is granted.
- dbg_we  in  1  burst direction, sampled at burst start.
- dbg_addr  in  AW  burst start byte address.
- dbg_len  in  LENW  beats minus 1.
- dbg_wdata  in  DW  write data, consumed on each cycle dbg_gnt=1.
- dbg_gnt  out  1  beat issued this cycle.
- dbg_rvalid  out  1  read beat valid.
- dbg_rdata  out  DW  read data.
- dbg_busy  out  1  burst in progress.
- access_err  out  1  misalignment flag (see Optional Feature).
- mem_wr_en  out  1  to memory write enable.
- mem_addr  out  AW  to memory address.
- mem_din  out  DW  to memory write data.
- mem_dout  in  DW  from memory read data.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, dbg_busy, mem_wr_en and access_err all 0; mem_addr and mem_din 0; beat counter and address register cleared; last_owner = DBG.
- Reset asserted mid-burst aborts the burst immediately. There is no resume; the debug side must re-request.
- States:
  - IDLE: arbitrate.
  - CPU: single access, one cycle.
  - DBG: burst.
- IDLE/CPU arbitration (combinational, same cycle):
  - Only cpu_req: grant CPU.
  - Only dbg_req: start burst.
  - Both: round-robin against last_owner. The owner that did not go last wins.
- CPU grant:
  - cpu_gnt=1; mem_addr=cpu_addr; mem_din=cpu_wdata; mem_wr_en=cpu_we.
  - last_owner<=CPU.
  - Back-to-back CPU grants every cycle are allowed while dbg_req=0.
- Burst start (cycle 0):
  - dbg_gnt=1; mem_addr=dbg_addr; mem_wr_en=dbg_we.
  - Latch addr+4, dbg_we, and remaining=dbg_len.
  - Go to DBG if dbg_len>0, else to IDLE. last_owner<=DBG.
- DBG state:
  - One beat per cycle; dbg_gnt=1; mem_addr=address register; mem_wr_en=latched we.
  - Address register +4 per beat, wrapping modulo 2^AW (0xFFFFFFFC -> 0x00000000).
  - remaining decrements each beat; after the beat with remaining==0, return to IDLE.
  - cpu_gnt=0 throughout. dbg_busy=1 from the start beat through the last beat.
- Post-burst fairness: if cpu_req=1 when the burst ends, the CPU wins the next cycle even if dbg_req=1.
- Read return:
  - A granted read registers an owner tag; the next cycle asserts that owner's rvalid for 1 cycle.
  - rdata = mem_dout combinationally. The other rdata holds its last value.
- Writes produce no rvalid.
- When no grant is issued, mem_wr_en=0 and mem_addr/mem_din hold their previous values.
- Only one access reaches memory per cycle; the CPU and debug ports are never granted in the same cycle.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- With the macro defined:
  - A granted access with addr[1:0]!=0 still consumes its grant.
  - For a write, mem_wr_en is forced to 0. For a read, rvalid is still returned and rdata is forced to 0.
  - access_err pulses 1 in the grant cycle.
  - In a burst, only the start address can be misaligned, and every beat is flagged.
- Without the macro: access_err is tied 0 and the address passes through unchecked.

Test Plan:
- Reset, then CPU writes 1,2,3,4 to 0x04,0x08,0x0C,0x10 on consecutive cycles -> cpu_gnt=1 each cycle, mem_wr_en=1, mem_addr follows; then CPU reads 0x04..0x10 -> cpu_rvalid one cycle after each read, rdata = 1,2,3,4.
- dbg_req, dbg_we=1, dbg_addr=0x20, dbg_len=3, wdata 0xA..0xD -> 4 beats at 0x20,0x24,0x28,0x2C; dbg_busy=1 for 4 cycles; a CPU read of 0x24 that is held stalls until then, then returns 0xB.
- cpu_req and dbg_req rise in the same cycle after reset (last_owner=DBG) -> CPU granted first; on the next cycle with both requesting -> debug burst starts; after a burst with cpu_req pending -> CPU wins.
- Burst read at dbg_addr=0xFFFFFFF8, dbg_len=2 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; dbg_rvalid 3 consecutive cycles lagging by 1.
- reset driven low in the 3rd beat of a dbg_len=7 burst -> all outputs 0 immediately; after release, state IDLE and a CPU read is granted the first cycle.
- With DMEM_ALIGN_CHECK_EN: CPU write at 0x06 -> cpu_gnt=1, mem_wr_en=0, access_err=1; a subsequent read of 0x04 returns the unchanged value.
